// File: rtl/palette_ram.sv
// rtl/palette_ram.sv - writable colour palette with registered lookup and frame-driven colour cycling
module palette_ram #(
   parameter int IDX_W    = 4,
   parameter int COLOR_W  = 24,
   parameter int PERIOD_W = 6
) (
   input  logic                Clk,
   input  logic                Reset,
   input  logic                frame_start,
   input  logic                wr_en,
   input  logic [IDX_W-1:0]    wr_idx,
   input  logic [COLOR_W-1:0]  wr_data,
   input  logic                cyc_en,
   input  logic [IDX_W-1:0]    cyc_lo,
   input  logic [IDX_W-1:0]    cyc_hi,
   input  logic [PERIOD_W-1:0] cyc_period,
   input  logic                pix_valid,
   input  logic [IDX_W-1:0]    pix_idx,
   input  logic                blank,
   output logic [COLOR_W-1:0]  rgb_out,
   output logic                rgb_valid
);

   localparam int DEPTH = 2**IDX_W;
   localparam logic [IDX_W:0]    ONE_W = 1;
   localparam logic [PERIOD_W-1:0] ONE_P = 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t               state;
   logic [COLOR_W-1:0]   mem [DEPTH];
   logic [IDX_W-1:0]     offset;
   logic [PERIOD_W-1:0]  frame_cnt;

   logic                 range_on;
   logic                 in_range;
   logic [IDX_W:0]       range_len;
   logic [IDX_W:0]       off_mod;
   logic [IDX_W:0]       off_inc;
   logic [IDX_W:0]       rel;
   logic [IDX_W-1:0]     eff_idx;
   logic [COLOR_W-1:0]   rd_data;
   logic [PERIOD_W-1:0]  period_max;

   function automatic logic [COLOR_W-1:0] def_color(input int i);
      logic [23:0] c;
      case (i)
         0:  c = 24'hB0B0B0;
         1:  c = 24'h0E490A;
         2:  c = 24'h1A8512;
         3:  c = 24'h21D113;
         4:  c = 24'h0F3D82;
         5:  c = 24'h1C70EE;
         6:  c = 24'h75A6F0;
         7:  c = 24'h801313;
         8:  c = 24'hE60E0E;
         9:  c = 24'hE66868;
         10: c = 24'h00FFFF;
         11: c = 24'hFAF7F8;
         12: c = 24'h5596F0;
         13: c = 24'h3A5728;
         14: c = 24'h96C03D;
         15: c = 24'h272233;
         default: c = 24'h000000;
      endcase
      return COLOR_W'(c);
   endfunction

   // Offset is reduced mod len combinationally so a shrunken range never maps outside itself.
   always_comb begin
      range_len  = {1'b0, cyc_hi} - {1'b0, cyc_lo} + ONE_W;
      range_on   = cyc_en && (cyc_lo <= cyc_hi);
      in_range   = range_on && (pix_idx >= cyc_lo) && (pix_idx <= cyc_hi);
      off_mod    = range_on ? ({1'b0, offset} % range_len) : '0;
      off_inc    = off_mod + ONE_W;
      if (off_inc == range_len) off_inc = '0;
      rel        = in_range ? (({1'b0, pix_idx} - {1'b0, cyc_lo} + {1'b0, offset}) % range_len) : '0;
      eff_idx    = in_range ? (cyc_lo + IDX_W'(rel)) : pix_idx;
      rd_data    = (wr_en && (wr_idx == eff_idx)) ? wr_data : mem[eff_idx];
      period_max = (cyc_period == '0) ? ONE_P : cyc_period;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         rgb_out   <= '0;
         rgb_valid <= 1'b0;
         offset    <= '0;
         frame_cnt <= '0;
         state     <= IDLE;
         for (int i = 0; i < DEPTH; i++) mem[i] <= def_color(i);
      end else begin
         rgb_valid <= pix_valid;
         if (pix_valid) rgb_out <= blank ? '0 : rd_data;
         if (wr_en) mem[wr_idx] <= wr_data;
         case (state)
            IDLE: begin
               offset    <= '0;
               frame_cnt <= '0;
               if (cyc_en) state <= RUN;
            end
            RUN: begin
               if (!cyc_en) begin
                  state     <= IDLE;
                  offset    <= '0;
                  frame_cnt <= '0;
               end else if (!range_on) begin
                  offset    <= '0;
                  frame_cnt <= '0;
               end else if (frame_start) begin
                  if (frame_cnt >= period_max - ONE_P) begin
                     frame_cnt <= '0;
                     offset    <= IDX_W'(off_inc);
                  end else begin
                     frame_cnt <= frame_cnt + ONE_P;
                     offset    <= IDX_W'(off_mod);
                  end
               end else begin
                  offset <= IDX_W'(off_mod);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_palette_ram.sv
// tb/tb_palette_ram.sv - self-checking bench for palette_ram against a behavioural model
module tb_palette_ram;

   logic        Clk = 1'b0;
   logic        Reset, frame_start, wr_en, cyc_en, pix_valid, blank;
   logic [3:0]  wr_idx, cyc_lo, cyc_hi, pix_idx;
   logic [23:0] wr_data;
   logic [5:0]  cyc_period;
   logic [23:0] rgb_out;
   logic        rgb_valid;

   int total = 0;
   int bad   = 0;

   logic [23:0] def_tab [16];
   logic [23:0] pal [16];
   int          m_off, m_cnt;
   bit          m_run;
   logic [23:0] exp_rgb;
   logic        exp_valid;

   palette_ram dut (
      .Clk(Clk), .Reset(Reset), .frame_start(frame_start),
      .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
      .cyc_en(cyc_en), .cyc_lo(cyc_lo), .cyc_hi(cyc_hi), .cyc_period(cyc_period),
      .pix_valid(pix_valid), .pix_idx(pix_idx), .blank(blank),
      .rgb_out(rgb_out), .rgb_valid(rgb_valid)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   function automatic int eff(input int p);
      int lo, hi, len;
      lo = int'(cyc_lo);
      hi = int'(cyc_hi);
      if (cyc_en && lo <= hi && p >= lo && p <= hi) begin
         len = hi - lo + 1;
         return lo + ((p - lo + m_off) % len);
      end
      return p;
   endfunction

   // Predict this edge from the spec rules, advance the edge, then compare.
   task automatic tick();
      int e, len, pm;
      logic [23:0] rd;
      if (Reset) begin
         for (int i = 0; i < 16; i++) pal[i] = def_tab[i];
         m_off = 0; m_cnt = 0; m_run = 0;
         exp_rgb = '0; exp_valid = 1'b0;
      end else begin
         exp_valid = pix_valid;
         e  = eff(int'(pix_idx));
         rd = (wr_en && int'(wr_idx) == e) ? wr_data : pal[e];
         if (pix_valid) exp_rgb = blank ? 24'h0 : rd;
         if (wr_en) pal[wr_idx] = wr_data;
         if (!cyc_en) begin
            m_run = 0; m_off = 0; m_cnt = 0;
         end else if (!m_run) begin
            m_run = 1;
         end else if (cyc_lo > cyc_hi) begin
            m_off = 0; m_cnt = 0;
         end else begin
            len   = int'(cyc_hi) - int'(cyc_lo) + 1;
            m_off = m_off % len;
            if (frame_start) begin
               pm = (cyc_period == 0) ? 1 : int'(cyc_period);
               m_cnt++;
               if (m_cnt >= pm) begin
                  m_cnt = 0;
                  m_off = (m_off + 1) % len;
               end
            end
         end
      end
      @(posedge Clk);
      #1;
      check("valid", {23'b0, rgb_valid}, {23'b0, exp_valid});
      check("rgb", rgb_out, exp_rgb);
   endtask

   initial begin
      def_tab = '{24'hB0B0B0, 24'h0E490A, 24'h1A8512, 24'h21D113,
                  24'h0F3D82, 24'h1C70EE, 24'h75A6F0, 24'h801313,
                  24'hE60E0E, 24'hE66868, 24'h00FFFF, 24'hFAF7F8,
                  24'h5596F0, 24'h3A5728, 24'h96C03D, 24'h272233};
      Reset = 1; frame_start = 0; wr_en = 0; wr_idx = 0; wr_data = 0;
      cyc_en = 0; cyc_lo = 0; cyc_hi = 0; cyc_period = 0;
      pix_valid = 0; pix_idx = 0; blank = 0;
      tick(); tick();
      check("reset_rgb", rgb_out, 24'h0);
      check("reset_valid", {23'b0, rgb_valid}, 24'h0);
      Reset = 0;

      pix_valid = 1;
      pix_idx = 0;  tick(); check("idx0", rgb_out, 24'hB0B0B0);
      pix_idx = 5;  tick(); check("idx5", rgb_out, 24'h1C70EE);
      pix_idx = 15; tick(); check("idx15", rgb_out, 24'h272233);

      wr_en = 1; wr_idx = 3; wr_data = 24'h123456; pix_idx = 3;
      tick(); check("bypass", rgb_out, 24'h123456);
      wr_en = 0;
      tick(); check("idx3_after_wr", rgb_out, 24'h123456);

      blank = 1; pix_idx = 8; tick(); check("blank", rgb_out, 24'h0);
      check("blank_valid", {23'b0, rgb_valid}, 24'h1);
      blank = 0; tick(); check("idx8", rgb_out, 24'hE60E0E);

      pix_valid = 0; cyc_lo = 1; cyc_hi = 3; cyc_period = 2; cyc_en = 1;
      tick();
      frame_start = 1; tick(); tick(); frame_start = 0;
      pix_valid = 1;
      pix_idx = 1; tick(); check("cyc_idx1", rgb_out, 24'h1A8512);
      pix_idx = 3; tick(); check("cyc_idx3", rgb_out, 24'h0E490A);
      pix_idx = 4; tick(); check("cyc_idx4", rgb_out, 24'h0F3D82);
      pix_valid = 0; frame_start = 1;
      repeat (4) tick();
      frame_start = 0; pix_valid = 1;
      pix_idx = 1; tick(); check("wrap_idx1", rgb_out, 24'h0E490A);
      pix_idx = 4; tick(); check("wrap_idx4", rgb_out, 24'h0F3D82);

      cyc_lo = 5; cyc_hi = 2; pix_valid = 0; frame_start = 1;
      repeat (3) tick();
      frame_start = 0; pix_valid = 1; pix_idx = 5;
      tick(); check("disabled_range", rgb_out, 24'h1C70EE);

      cyc_lo = 1; cyc_hi = 3; cyc_period = 0; pix_valid = 0; frame_start = 1;
      tick(); tick();
      frame_start = 0; pix_valid = 1; pix_idx = 1;
      tick(); check("period0_idx1", rgb_out, 24'h123456);

      Reset = 1; tick();
      check("midrst_valid", {23'b0, rgb_valid}, 24'h0);
      Reset = 0; pix_idx = 3;
      tick(); check("midrst_idx3", rgb_out, 24'h21D113);

      repeat (600) begin
         Reset       = ($urandom_range(0, 149) == 0);
         frame_start = ($urandom_range(0, 3) == 0);
         wr_en       = ($urandom_range(0, 3) == 0);
         wr_idx      = 4'($urandom);
         wr_data     = 24'($urandom);
         cyc_en      = ($urandom_range(0, 15) != 0);
         if ($urandom_range(0, 15) == 0) begin
            cyc_lo = 4'($urandom);
            cyc_hi = 4'($urandom);
         end
         cyc_period  = 6'($urandom_range(0, 3));
         pix_valid   = ($urandom_range(0, 3) != 0);
         pix_idx     = 4'($urandom);
         blank       = ($urandom_range(0, 7) == 0);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
